// File: rtl/afifo_pkg.sv
// Shared dual-clock FIFO helpers: pointer code conversions and depth derivation.
// Functions work on zero-extended pointers up to MAX_PTR_W bits, so any width fits.
package afifo_pkg;

  localparam int MAX_PTR_W = 11;

  typedef logic [MAX_PTR_W-1:0] ptr_t;

  function automatic int afifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    for (int i = 0; i < MAX_PTR_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_gray2bin.sv
// Combinational Gray-to-binary converter, zero latency; no flow control.
// MSB passes through, each lower bit folds in every Gray bit above it.
module afifo_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-side pointer/flag controller for the dual-clock FIFO; flags registered one cycle after the write.
// Writes while full are rejected (wr_mem_en low) and latch the sticky overflow flag.
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int AFULL_TH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W:0]   rptr_sync,
  input  logic              ovf_clr,
  output logic              wr_mem_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic [ADDR_W:0]   gray_wptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = afifo_depth(ADDR_W);
  localparam int TH    = (AFULL_TH > DEPTH) ? DEPTH : AFULL_TH;
  localparam logic [PW-1:0] TH_L = PW'(TH);

  logic            acc;
  logic [PW-1:0]   wptr_next;
  logic [PW-1:0]   gray_next;
  logic [PW-1:0]   rbin;
  logic [PW-1:0]   rptr_full_pat;
  logic [PW-1:0]   level_next;

  afifo_gray2bin #(.W(PW)) u_rptr_g2b (
    .gray (rptr_sync),
    .bin  (rbin)
  );

  assign acc       = wr & ~full;
  assign wr_mem_en = acc;
  assign waddr     = wptr[ADDR_W-1:0];

  assign wptr_next = wptr + {{ADDR_W{1'b0}}, acc};
  assign gray_next = wptr_next ^ (wptr_next >> 1);

  // In Gray code "one lap ahead" means the top two bits inverted, the rest equal.
  assign rptr_full_pat = {~rptr_sync[ADDR_W:ADDR_W-1], rptr_sync[ADDR_W-2:0]};
  assign level_next    = wptr_next - rbin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr        <= '0;
      gray_wptr   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wptr        <= wptr_next;
      gray_wptr   <= gray_next;
      full        <= (gray_next == rptr_full_pat);
      almost_full <= (level_next >= TH_L);
      wr_level    <= level_next;
      if (wr && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed bench for afifo_wr_ctrl: default 8-deep instance plus a 16-deep instance.
module tb_afifo_wr_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-deep instance
  logic       rst_n, wr, ovf_clr;
  logic [3:0] rptr_sync;
  logic       wr_mem_en, full, almost_full, overflow;
  logic [2:0] waddr;
  logic [3:0] wptr, gray_wptr, wr_level;

  // 16-deep instance
  logic       rst_n4, wr4, ovf_clr4;
  logic [4:0] rptr_sync4;
  logic       wr_mem_en4, full4, almost_full4, overflow4;
  logic [3:0] waddr4;
  logic [4:0] wptr4, gray_wptr4, wr_level4;

  int checks = 0;
  int passed = 0;

  afifo_wr_ctrl #(.ADDR_W(3), .AFULL_TH(6)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rptr_sync(rptr_sync), .ovf_clr(ovf_clr),
    .wr_mem_en(wr_mem_en), .waddr(waddr), .wptr(wptr), .gray_wptr(gray_wptr),
    .full(full), .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  afifo_wr_ctrl #(.ADDR_W(4), .AFULL_TH(16)) dut4 (
    .clk(clk), .rst_n(rst_n4), .wr(wr4), .rptr_sync(rptr_sync4), .ovf_clr(ovf_clr4),
    .wr_mem_en(wr_mem_en4), .waddr(waddr4), .wptr(wptr4), .gray_wptr(gray_wptr4),
    .full(full4), .almost_full(almost_full4), .wr_level(wr_level4), .overflow(overflow4)
  );

  function automatic logic [3:0] g4(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr = 1'b0; ovf_clr = 1'b0; rptr_sync = 4'd0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b1; ovf_clr = 1'b0; rptr_sync = 4'd0;
    step();
    step();
    checks++;
    if ({wptr, gray_wptr, wr_level, full, almost_full, overflow} !== 15'd0)
      $display("FAIL reset_state: wptr=%h gray=%h lvl=%h full=%b af=%b ovf=%b, want all 0",
               wptr, gray_wptr, wr_level, full, almost_full, overflow);
    else passed++;
    wr = 1'b0;
    #1;
    checks++;
    if (wr_mem_en !== 1'b0) $display("FAIL reset_wr_mem_en: got %b want 0", wr_mem_en);
    else passed++;
    rst_n = 1'b1; wr = 1'b1;
    step();
    wr = 1'b0;
    checks++;
    if (wptr !== 4'd1 || gray_wptr !== 4'b0001 || wr_level !== 4'd1)
      $display("FAIL first_write: wptr=%h gray=%b lvl=%0d want 1/0001/1", wptr, gray_wptr, wr_level);
    else passed++;
  endtask

  task automatic test_fill();
    do_reset();
    wr = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 5 || i == 6) begin
        checks++;
        if (almost_full !== (i == 6)) $display("FAIL fill_afull_%0d: got %b want %b", i, almost_full, i == 6);
        else passed++;
      end
      if (i == 7 || i == 8) begin
        checks++;
        if (full !== (i == 8)) $display("FAIL fill_full_%0d: got %b want %b", i, full, i == 8);
        else passed++;
      end
    end
    checks++;
    if (wptr !== 4'd8 || gray_wptr !== 4'b1100 || wr_level !== 4'd8 || overflow !== 1'b0)
      $display("FAIL fill_state: wptr=%0d gray=%b lvl=%0d ovf=%b want 8/1100/8/0",
               wptr, gray_wptr, wr_level, overflow);
    else passed++;
    checks++;
    if (wr_mem_en !== 1'b0) $display("FAIL fill_block_en: got %b want 0", wr_mem_en);
    else passed++;
    step();
    wr = 1'b0;
    checks++;
    if (wptr !== 4'd8 || overflow !== 1'b1 || full !== 1'b1)
      $display("FAIL fill_overflow: wptr=%0d ovf=%b full=%b want 8/1/1", wptr, overflow, full);
    else passed++;
  endtask

  task automatic test_ovf_clr();
    wr = 1'b0; ovf_clr = 1'b1;
    step();
    checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
    else passed++;
    wr = 1'b1;
    step();
    step();
    checks++;
    if (overflow !== 1'b1 || wptr !== 4'd8)
      $display("FAIL ovf_set_wins: ovf=%b wptr=%0d want 1/8", overflow, wptr);
    else passed++;
    wr = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_drain();
    rptr_sync = 4'b0010;
    step();
    checks++;
    if (full !== 1'b0 || wr_level !== 4'd5 || almost_full !== 1'b0)
      $display("FAIL drain_flags: full=%b lvl=%0d af=%b want 0/5/0", full, wr_level, almost_full);
    else passed++;
    wr = 1'b1;
    #1;
    checks++;
    if (wr_mem_en !== 1'b1 || waddr !== 3'd0)
      $display("FAIL drain_resume_en: en=%b waddr=%0d want 1/0", wr_mem_en, waddr);
    else passed++;
    step();
    wr = 1'b0;
    checks++;
    if (wptr !== 4'd9 || wr_level !== 4'd6 || almost_full !== 1'b1 || full !== 1'b0)
      $display("FAIL drain_resume: wptr=%0d lvl=%0d af=%b full=%b want 9/6/1/0",
               wptr, wr_level, almost_full, full);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [3:0] w_exp, rb, lvl_exp, prev_g, diff;
    do_reset();
    w_exp = 4'd0;
    prev_g = 4'd0;
    wr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rb = (i < 2) ? 4'd0 : w_exp - 4'd2;
      rptr_sync = g4(rb);
      step();
      w_exp   = w_exp + 4'd1;
      lvl_exp = w_exp - rb;
      diff    = gray_wptr ^ prev_g;
      checks++;
      if (wptr !== w_exp || gray_wptr !== g4(w_exp) || wr_level !== lvl_exp || full !== 1'b0 ||
          $countones(diff) != 1)
        $display("FAIL wrap_%0d: wptr=%0d gray=%b lvl=%0d full=%b want %0d/%b/%0d/0 1-bit step",
                 i, wptr, gray_wptr, wr_level, full, w_exp, g4(w_exp), lvl_exp);
      else passed++;
      prev_g = gray_wptr;
    end
    wr = 1'b0;
  endtask

  task automatic test_param();
    rst_n4 = 1'b0; wr4 = 1'b0; ovf_clr4 = 1'b0; rptr_sync4 = 5'd0;
    step();
    rst_n4 = 1'b1; wr4 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 15) begin
        checks++;
        if (full4 !== 1'b0 || almost_full4 !== 1'b0 || wr_level4 !== 5'd15)
          $display("FAIL param_15: full=%b af=%b lvl=%0d want 0/0/15", full4, almost_full4, wr_level4);
        else passed++;
      end
    end
    wr4 = 1'b0;
    checks++;
    if (full4 !== 1'b1 || almost_full4 !== 1'b1 || wr_level4 !== 5'd16 || wptr4 !== 5'd16 ||
        gray_wptr4 !== 5'b11000)
      $display("FAIL param_16: full=%b af=%b lvl=%0d wptr=%0d gray=%b want 1/1/16/16/11000",
               full4, almost_full4, wr_level4, wptr4, gray_wptr4);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; ovf_clr = 1'b0; rptr_sync = 4'd0;
    rst_n4 = 1'b0; wr4 = 1'b0; ovf_clr4 = 1'b0; rptr_sync4 = 5'd0;
    #2;
    test_reset();
    test_fill();
    test_ovf_clr();
    test_drain();
    test_wrap();
    test_param();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
